// File: rtl/player_speed_scheduler_if.sv
// Control and status bundle between the input/pickup logic, the speed scheduler
// and the movement block.
interface player_speed_scheduler_if;
   logic       startOfFrame;
   logic       sw_inc;
   logic       sw_dec;
   logic       powerUp_pulse;
   logic       death;
   logic [1:0] base_level;
   logic [1:0] speed_level;
   logic       boost_active;
   logic       boost_warn;
   logic [9:0] boost_frames_left;
   logic       move_tick;

   modport master (
      output startOfFrame, sw_inc, sw_dec, powerUp_pulse, death,
      input  base_level, speed_level, boost_active, boost_warn,
             boost_frames_left, move_tick
   );

   modport slave (
      input  startOfFrame, sw_inc, sw_dec, powerUp_pulse, death,
      output base_level, speed_level, boost_active, boost_warn,
             boost_frames_left, move_tick
   );
endinterface

// File: rtl/player_speed_scheduler.sv
// Per-player speed controller: debug switch level, timed power-up boost with a
// warning tail, and a frame divider that turns the effective level into move ticks.
module player_speed_scheduler #(
   parameter int MAX_LEVEL    = 2,
   parameter int BOOST_FRAMES = 600,
   parameter int WARN_FRAMES  = 120,
   parameter int DIV_BASE     = 4
) (
   input logic                      clk,
   input logic                      resetN,
   player_speed_scheduler_if.slave  bus
);

   localparam logic [1:0] IDLE_ST  = 2'd0;
   localparam logic [1:0] BOOST_ST = 2'd1;
   localparam logic [1:0] WARN_ST  = 2'd2;

   localparam logic [1:0] MAX_LVL  = 2'(MAX_LEVEL);
   localparam logic [9:0] BOOST_LD = 10'(BOOST_FRAMES);
   localparam logic [9:0] WARN_LIM = 10'(WARN_FRAMES);
   localparam logic [2:0] DIV_M1   = 3'(DIV_BASE - 1);

   logic       sw_inc_prev_r;
   logic       sw_dec_prev_r;
   logic [1:0] base_level_r;
   logic [1:0] state_r;
   logic [9:0] frames_left_r;
   logic       boost_active_r;
   logic       boost_warn_r;
   logic [1:0] move_cnt_r;
   logic       move_tick_r;

   logic       inc_edge_s;
   logic       dec_edge_s;
   logic [1:0] base_next_s;
   logic [1:0] state_next_s;
   logic [9:0] frames_next_s;
   logic [9:0] frames_dec_s;
   logic [2:0] level_sum_s;
   logic [1:0] speed_level_s;
   logic [2:0] fire_thresh_s;
   logic       fire_s;
   logic [1:0] move_cnt_next_s;
   logic       move_tick_next_s;

   assign inc_edge_s = bus.sw_inc & ~sw_inc_prev_r;
   assign dec_edge_s = bus.sw_dec & ~sw_dec_prev_r;

   // Saturating switch level; simultaneous edges cancel out.
   always_comb begin
      base_next_s = base_level_r;
      if (inc_edge_s && !dec_edge_s) begin
         if (base_level_r < MAX_LVL) begin
            base_next_s = base_level_r + 2'd1;
         end else begin
            base_next_s = base_level_r;
         end
      end else if (dec_edge_s && !inc_edge_s) begin
         if (base_level_r != 2'd0) begin
            base_next_s = base_level_r - 2'd1;
         end else begin
            base_next_s = base_level_r;
         end
      end else begin
         base_next_s = base_level_r;
      end
   end

   // Boost FSM: death beats a pickup, a pickup beats the per-frame countdown.
   always_comb begin
      state_next_s  = state_r;
      frames_next_s = frames_left_r;
      frames_dec_s  = frames_left_r - 10'd1;
      if (bus.death) begin
         state_next_s  = IDLE_ST;
         frames_next_s = 10'd0;
      end else if (bus.powerUp_pulse) begin
         state_next_s  = BOOST_ST;
         frames_next_s = BOOST_LD;
      end else if (bus.startOfFrame) begin
         case (state_r)
            BOOST_ST, WARN_ST: begin
               frames_next_s = frames_dec_s;
               if (frames_dec_s == 10'd0) begin
                  state_next_s = IDLE_ST;
               end else if (frames_dec_s <= WARN_LIM) begin
                  state_next_s = WARN_ST;
               end else begin
                  state_next_s = BOOST_ST;
               end
            end
            IDLE_ST: begin
               state_next_s  = IDLE_ST;
               frames_next_s = frames_left_r;
            end
            default: begin
               state_next_s  = IDLE_ST;
               frames_next_s = 10'd0;
            end
         endcase
      end else begin
         state_next_s  = state_r;
         frames_next_s = frames_left_r;
      end
   end

   // Effective level: boost adds one, widened so the sum cannot wrap before saturation.
   always_comb begin
      level_sum_s = {1'b0, base_level_r} + {2'b00, (state_r != IDLE_ST)};
      if (level_sum_s > {1'b0, MAX_LVL}) begin
         speed_level_s = MAX_LVL;
      end else begin
         speed_level_s = level_sum_s[1:0];
      end
   end

   // Divider with >= compare so a level raised mid-period fires on the next frame.
   always_comb begin
      fire_thresh_s    = DIV_M1 - {1'b0, speed_level_s};
      fire_s           = ({1'b0, move_cnt_r} >= fire_thresh_s);
      move_cnt_next_s  = move_cnt_r;
      move_tick_next_s = 1'b0;
      if (bus.death) begin
         move_cnt_next_s  = 2'd0;
         move_tick_next_s = 1'b0;
      end else if (bus.startOfFrame) begin
         if (fire_s) begin
            move_cnt_next_s  = 2'd0;
            move_tick_next_s = 1'b1;
         end else begin
            move_cnt_next_s  = move_cnt_r + 2'd1;
            move_tick_next_s = 1'b0;
         end
      end else begin
         move_cnt_next_s  = move_cnt_r;
         move_tick_next_s = 1'b0;
      end
   end

   // Switch history resets high so a switch held through reset needs a fresh press.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sw_inc_prev_r <= 1'b1;
         sw_dec_prev_r <= 1'b1;
         base_level_r  <= 2'd0;
      end else begin
         sw_inc_prev_r <= bus.sw_inc;
         sw_dec_prev_r <= bus.sw_dec;
         base_level_r  <= base_next_s;
      end
   end

   // Boost state and its registered status flags.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_r        <= IDLE_ST;
         frames_left_r  <= 10'd0;
         boost_active_r <= 1'b0;
         boost_warn_r   <= 1'b0;
      end else begin
         state_r        <= state_next_s;
         frames_left_r  <= frames_next_s;
         boost_active_r <= (state_next_s != IDLE_ST);
         boost_warn_r   <= (state_next_s == WARN_ST);
      end
   end

   // Movement divider state and registered step pulse.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         move_cnt_r  <= 2'd0;
         move_tick_r <= 1'b0;
      end else begin
         move_cnt_r  <= move_cnt_next_s;
         move_tick_r <= move_tick_next_s;
      end
   end

   assign bus.base_level        = base_level_r;
   assign bus.speed_level       = speed_level_s;
   assign bus.boost_active      = boost_active_r;
   assign bus.boost_warn        = boost_warn_r;
   assign bus.boost_frames_left = frames_left_r;
   assign bus.move_tick         = move_tick_r;

endmodule

// File: tb/tb_player_speed_scheduler.sv
// Randomized and directed bench for player_speed_scheduler against a frame-count
// reference model.
module tb_player_speed_scheduler;

   localparam int MAXL  = 2;
   localparam int BOOST = 8;
   localparam int WARN  = 3;
   localparam int DIV   = 4;

   logic clk = 1'b0;
   logic resetN;

   player_speed_scheduler_if bus ();

   player_speed_scheduler #(
      .MAX_LEVEL   (MAXL),
      .BOOST_FRAMES(BOOST),
      .WARN_FRAMES (WARN),
      .DIV_BASE    (DIV)
   ) dut (
      .clk   (clk),
      .resetN(resetN),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model: boost is just "frames remaining", divider is frames since last step
   int m_base, m_frames, m_since, m_tick, m_pinc, m_pdec;

   task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int m_speed();
      int s;
      s = m_base + ((m_frames > 0) ? 1 : 0);
      return (s > MAXL) ? MAXL : s;
   endfunction

   task automatic model_reset();
      m_base = 0; m_frames = 0; m_since = 0; m_tick = 0; m_pinc = 1; m_pdec = 1;
   endtask

   task automatic model_edge();
      int  spd;
      bit  ie, de;
      spd = m_speed();
      ie  = (bus.sw_inc == 1'b1) && (m_pinc == 0);
      de  = (bus.sw_dec == 1'b1) && (m_pdec == 0);
      m_pinc = int'(bus.sw_inc);
      m_pdec = int'(bus.sw_dec);
      if (ie && !de && m_base < MAXL) m_base = m_base + 1;
      if (de && !ie && m_base > 0)    m_base = m_base - 1;
      m_tick = 0;
      if (bus.death) begin
         m_since = 0;
      end else if (bus.startOfFrame) begin
         // a step is due once this frame completes the period DIV - speed
         if (m_since + 1 >= DIV - spd) begin
            m_tick  = 1;
            m_since = 0;
         end else begin
            m_since = m_since + 1;
         end
      end
      if (bus.death)              m_frames = 0;
      else if (bus.powerUp_pulse) m_frames = BOOST;
      else if (bus.startOfFrame && m_frames > 0) m_frames = m_frames - 1;
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".base"},   32'(bus.base_level),        32'(m_base));
      check_val({tag, ".speed"},  32'(bus.speed_level),       32'(m_speed()));
      check_val({tag, ".active"}, 32'(bus.boost_active),      32'(m_frames > 0));
      check_val({tag, ".warn"},   32'(bus.boost_warn),        32'(m_frames > 0 && m_frames <= WARN));
      check_val({tag, ".left"},   32'(bus.boost_frames_left), 32'(m_frames));
      check_val({tag, ".tick"},   32'(bus.move_tick),         32'(m_tick));
   endtask

   task automatic cycle(input bit sof, input bit pu, input bit dth);
      bus.startOfFrame  = sof;
      bus.powerUp_pulse = pu;
      bus.death         = dth;
      @(posedge clk);
      if (resetN) model_edge();
      else        model_reset();
      #1;
      check_all("cyc");
      bus.startOfFrame  = 1'b0;
      bus.powerUp_pulse = 1'b0;
      bus.death         = 1'b0;
   endtask

   task automatic frame(output int ticked);
      cycle(1'b1, 1'b0, 1'b0);
      ticked = int'(bus.move_tick);
      cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_inc();
      bus.sw_inc = 1'b0; cycle(1'b0, 1'b0, 1'b0);
      bus.sw_inc = 1'b1; cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_dec();
      bus.sw_dec = 1'b0; cycle(1'b0, 1'b0, 1'b0);
      bus.sw_dec = 1'b1; cycle(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int t, nticks;
      resetN            = 1'b0;
      bus.sw_inc        = 1'b1;
      bus.sw_dec        = 1'b0;
      bus.startOfFrame  = 1'b0;
      bus.powerUp_pulse = 1'b0;
      bus.death         = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(posedge clk);
      #2 resetN = 1'b1;

      // switch held through reset is ignored until re-pressed
      repeat (10) cycle(1'b0, 1'b0, 1'b0);
      check_val("held_inc", 32'(bus.base_level), 32'd0);
      press_inc();
      check_val("first_inc", 32'(bus.base_level), 32'd1);
      repeat (3) press_inc();
      check_val("inc_sat", 32'(bus.base_level), 32'd2);

      // divider at level 0 then level 2
      press_dec(); press_dec();
      cycle(1'b0, 1'b0, 1'b1);
      nticks = 0;
      for (int i = 0; i < 8; i++) begin frame(t); nticks += t; end
      check_val("ticks_l0", 32'(nticks), 32'd2);
      press_inc(); press_inc();
      cycle(1'b0, 1'b0, 1'b1);
      nticks = 0;
      for (int i = 0; i < 6; i++) begin frame(t); nticks += t; end
      check_val("ticks_l2", 32'(nticks), 32'd3);

      // boost from level 0 runs its full length
      press_dec(); press_dec();
      cycle(1'b0, 1'b1, 1'b0);
      check_val("boost_speed", 32'(bus.speed_level), 32'd1);
      for (int i = 0; i < 8; i++) frame(t);
      check_val("boost_end_left", 32'(bus.boost_frames_left), 32'd0);
      check_val("boost_end_speed", 32'(bus.speed_level), 32'd0);

      // saturation and refresh from WARN
      press_inc(); press_inc();
      cycle(1'b0, 1'b1, 1'b0);
      check_val("sat_speed", 32'(bus.speed_level), 32'd2);
      for (int i = 0; i < 6; i++) frame(t);
      check_val("in_warn", 32'(bus.boost_warn), 32'd1);
      cycle(1'b0, 1'b1, 1'b0);
      check_val("refresh_left", 32'(bus.boost_frames_left), 32'd8);
      check_val("refresh_warn", 32'(bus.boost_warn), 32'd0);

      // same-cycle priorities
      cycle(1'b1, 1'b1, 1'b0);
      check_val("pu_sof_left", 32'(bus.boost_frames_left), 32'd8);
      cycle(1'b0, 1'b1, 1'b1);
      check_val("death_pu_left", 32'(bus.boost_frames_left), 32'd0);
      check_val("death_pu_base", 32'(bus.base_level), 32'd2);

      // simultaneous switch edges at level 1
      press_dec();
      bus.sw_inc = 1'b0; bus.sw_dec = 1'b0; cycle(1'b0, 1'b0, 1'b0);
      bus.sw_inc = 1'b1; bus.sw_dec = 1'b1; cycle(1'b0, 1'b0, 1'b0);
      check_val("both_edges", 32'(bus.base_level), 32'd1);

      // asynchronous reset while in WARN
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) frame(t);
      check_val("pre_reset_warn", 32'(bus.boost_warn), 32'd1);
      #2 resetN = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      #2 resetN = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      check_val("no_residual", 32'(bus.boost_active), 32'd0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(7, 0) == 0) bus.sw_inc = ~bus.sw_inc;
         if ($urandom_range(7, 0) == 0) bus.sw_dec = ~bus.sw_dec;
         cycle($urandom_range(2, 0) == 0, $urandom_range(24, 0) == 0, $urandom_range(49, 0) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/player_speed_scheduler.md
# player_speed_scheduler

Per-player speed controller sitting between the input/pickup logic and the player movement block. Merges debug switch requests and power-up pickups into one effective speed level and runs a timed boost with an end-of-boost warning phase. Converts the speed level into a per-frame movement step enable.

## Interface
- MAX_LEVEL, 2: highest effective speed level (≤ 3).
- BOOST_FRAMES, 600: frames a power-up boost lasts (1..1023).
- WARN_FRAMES, 120: final boost frames flagged as warning (< BOOST_FRAMES).
- DIV_BASE, 4: frame divisor; move period = DIV_BASE − speed_level frames (DIV_BASE > MAX_LEVEL).
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per video frame.
- sw_inc  in  1  debug increment switch, level; acts on rising edge only.
- sw_dec  in  1  debug decrement switch, level; acts on rising edge only.
- powerUp_pulse  in  1  one-cycle speed pickup event.
- death  in  1  one-cycle player-death event.
- base_level  out  2  switch-controlled level, 0..MAX_LEVEL.
- speed_level  out  2  effective level = min(base_level + boost_active, MAX_LEVEL).
- boost_active  out  1  high in BOOST or WARN.
- boost_warn  out  1  high in WARN only (drives player blink).
- boost_frames_left  out  10  remaining boost frames.
- move_tick  out  1  one-cycle step enable for movement block.

## Operation
- Boost FSM states: IDLE, BOOST, WARN.
  - IDLE --powerUp_pulse--> BOOST, boost_frames_left ← BOOST_FRAMES.
  - BOOST/WARN --powerUp_pulse--> BOOST, reload BOOST_FRAMES. A refresh does not stack; the boost contributes +1 only.
  - BOOST/WARN on startOfFrame without powerUp_pulse: decrement. Enter WARN when the new value is ≤ WARN_FRAMES. Enter IDLE when the new value is 0.
  - Any state --death--> IDLE, boost_frames_left ← 0.
- Priority within one cycle: death > powerUp_pulse > startOfFrame decrement.
- Debug switches:
  - Previous-value registers reset to 1, so a switch held through reset does nothing until it is released and pressed again.
  - Rising edge of sw_inc: base_level +1, saturating at MAX_LEVEL.
  - Rising edge of sw_dec: base_level −1, saturating at 0.
  - Rising edges of both in the same cycle: no change.
  - death does not change base_level.
- speed_level is combinational from base_level and the FSM state. The sum is computed 3 bits wide, then saturated to MAX_LEVEL.
- Move divider: 2-bit counter move_cnt.
  - On startOfFrame, if move_cnt ≥ DIV_BASE − 1 − speed_level: move_tick pulses and move_cnt ← 0.
  - Otherwise move_cnt +1.
  - The ≥ compare makes a mid-period level increase fire on the next frame instead of wrapping.
  - death clears move_cnt.

## Timing
- Reset values:
  - base_level 0, speed_level 0.
  - FSM IDLE, boost_active 0, boost_warn 0, boost_frames_left 0.
  - move_cnt 0, move_tick 0.
  - switch previous registers 1.
- All state updates occur on the clock edge that samples the input. Registered outputs and speed_level reflect the change in the following cycle (1-cycle latency).
- move_tick is registered: high exactly in the cycle after the qualifying startOfFrame, one cycle wide.
- The divider uses speed_level as it stands in the startOfFrame cycle. A boost start and a frame in the same cycle use the pre-boost level.
- Reset asserted mid-boost returns all outputs to reset values asynchronously. There is no residual boost after release.
- startOfFrame pulses closer together than one cycle are not supported.

## Test plan
Bench parameters: BOOST_FRAMES=8, WARN_FRAMES=3, DIV_BASE=4, MAX_LEVEL=2.

- Reset with sw_inc held high, release reset, hold 10 cycles -> base_level stays 0. Drop sw_inc, raise it -> base_level 1 one cycle later. Three more presses -> saturates at 2.
- Level 0, 8 startOfFrame pulses -> move_tick after frames 4 and 8 only. At base_level 2, 6 frames -> ticks after frames 2, 4, 6.
- base_level 0, powerUp_pulse, then 8 frames:
  - speed_level 1 and boost_active 1 from the next cycle.
  - boost_warn rises when boost_frames_left reaches 3.
  - After the 8th frame: IDLE, speed_level 0, boost_frames_left 0.
- base_level 2, powerUp_pulse -> speed_level stays 2 (saturation). powerUp_pulse again when boost_frames_left=2 (WARN) -> BOOST, boost_frames_left=8, boost_warn 0.
- powerUp_pulse and startOfFrame in the same cycle -> boost_frames_left=8, not 7. death and powerUp_pulse in the same cycle -> IDLE, boost_frames_left 0, base_level unchanged.
- Rising edges of sw_inc and sw_dec in the same cycle at base_level 1 -> stays 1. Deassert resetN while in WARN -> all outputs at reset values before the next clock edge.
